uz_error_handler_axil_slave: RTL

AXI4-Lite responder for the error handler: accepts single-beat writes/reads from the PS master on S00_AXI and exposes four 32-bit registers (control, mask, sticky status, event counter). Latches incoming error lines into write-1-to-clear status, counts new error events and drives a level interrupt. Sits between the AXI interconnect and the error-source fabric inside the uz_error_handler IP.

---
 rtl/uz_error_handler_pkg.sv | 39 +++
 rtl/uz_error_handler_status.sv | 54 +++++
 rtl/uz_error_handler_axil_slave.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uz_error_handler_pkg.sv
// Shared constants, FSM state types and helpers for the uz_error_handler AXI4-Lite slave.
package uz_error_handler_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_MASK   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;

    localparam int CTRL_EN_BIT = 0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    // Word slots 4..7 (offsets 0x10-0x1C) are unmapped.
    function automatic logic is_implemented(input logic [2:0] idx);
        return ~idx[2];
    endfunction

endpackage

// File: rtl/uz_error_handler_status.sv
// Sticky error status (W1C), saturating new-event counter and registered level interrupt.
module uz_error_handler_status
    import uz_error_handler_pkg::*;
#(
    parameter int ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [ERR_WIDTH-1:0] mask,
    input  logic [ERR_WIDTH-1:0] err,
    input  logic [ERR_WIDTH-1:0] status_clr,
    input  logic                 count_clr,
    output logic [ERR_WIDTH-1:0] status,
    output logic [31:0]          count,
    output logic                 irq
);

    logic [ERR_WIDTH-1:0] status_set;
    logic [ERR_WIDTH-1:0] status_next;
    logic                 new_event;

    // A bit raised by err in the same cycle as its W1C stays set.
    assign status_set  = enable ? err : '0;
    assign status_next = (status & ~status_clr) | status_set;
    assign new_event   = |(status_next & ~status & ~mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else begin
            status <= status_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count_clr) begin
            count <= '0;
        end else if (new_event && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status & ~mask);
        end
    end

endmodule

// File: rtl/uz_error_handler_axil_slave.sv
// AXI4-Lite register front-end of the uz_error_handler IP (CTRL, MASK, STATUS, COUNT).
// Define UZ_ERROR_HANDLER_SLVERR_EN to answer unmapped offsets with SLVERR instead of OKAY.
//
// state  | meaning
// W_IDLE | waiting for awvalid and wvalid together
// W_ACK  | awready/wready high, register write at end of cycle
// W_RESP | bvalid high until bready
// R_IDLE | waiting for arvalid
// R_ACK  | arready high, rdata/rresp captured at end of cycle
// R_DATA | rvalid high until rready
module uz_error_handler_axil_slave
    import uz_error_handler_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 5,
    parameter int ERR_WIDTH            = 16
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic [ERR_WIDTH-1:0]              err_i,
    output logic                              irq_o
);

`ifdef UZ_ERROR_HANDLER_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [31:0]          ctrl_reg;
    logic [31:0]          mask_reg;
    logic [ERR_WIDTH-1:0] status;
    logic [31:0]          status_word;
    logic [31:0]          count;
    logic [31:0]          wr_mask;
    logic [31:0]          rd_word;
    logic [2:0]           wr_idx;
    logic [2:0]           rd_idx;
    logic                 wr_en;
    logic [ERR_WIDTH-1:0] status_clr;
    logic                 count_clr;
    logic                 unused;

    assign unused  = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign wr_idx  = s00_axi_awaddr[4:2];
    assign rd_idx  = s00_axi_araddr[4:2];
    assign wr_mask = strb_to_mask(s00_axi_wstrb);
    assign wr_en   = (w_state == W_ACK);

    // Write FSM
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid) w_state_next = W_ACK;
            W_ACK:  w_state_next = W_RESP;
            W_RESP: if (s00_axi_bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        s00_axi_awready = (w_state == W_ACK);
        s00_axi_wready  = (w_state == W_ACK);
        s00_axi_bvalid  = (w_state == W_RESP);
    end

    // Read FSM
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE: if (s00_axi_arvalid && !s00_axi_rvalid) r_state_next = R_ACK;
            R_ACK:  r_state_next = R_DATA;
            R_DATA: if (s00_axi_rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        s00_axi_arready = (r_state == R_ACK);
        s00_axi_rvalid  = (r_state == R_DATA);
    end

    // Register file
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl_reg      <= '0;
            mask_reg      <= '0;
            s00_axi_bresp <= RESP_OKAY;
        end else if (wr_en) begin
            if (wr_idx == REG_CTRL) ctrl_reg <= (ctrl_reg & ~wr_mask) | (s00_axi_wdata & wr_mask);
            if (wr_idx == REG_MASK) mask_reg <= (mask_reg & ~wr_mask) | (s00_axi_wdata & wr_mask);
            s00_axi_bresp <= is_implemented(wr_idx) ? RESP_OKAY : UNMAPPED_RESP;
        end
    end

    assign status_clr = (wr_en && (wr_idx == REG_STATUS)) ? s00_axi_wdata[ERR_WIDTH-1:0] & wr_mask[ERR_WIDTH-1:0] : '0;
    assign count_clr  = wr_en && (wr_idx == REG_COUNT);

    always_comb begin
        status_word                  = '0;
        status_word[ERR_WIDTH-1:0]   = status;
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            REG_CTRL:   rd_word = ctrl_reg;
            REG_MASK:   rd_word = mask_reg;
            REG_STATUS: rd_word = status_word;
            REG_COUNT:  rd_word = count;
            default:    rd_word = '0;
        endcase
    end

    // Captured on the arready cycle, so a same-cycle write is not yet visible.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_rdata <= '0;
            s00_axi_rresp <= RESP_OKAY;
        end else if (r_state == R_ACK) begin
            s00_axi_rdata <= rd_word;
            s00_axi_rresp <= is_implemented(rd_idx) ? RESP_OKAY : UNMAPPED_RESP;
        end
    end

    uz_error_handler_status #(
        .ERR_WIDTH (ERR_WIDTH)
    ) u_status (
        .clk        (s00_axi_aclk),
        .rst_n      (s00_axi_aresetn),
        .enable     (ctrl_reg[CTRL_EN_BIT]),
        .mask       (mask_reg[ERR_WIDTH-1:0]),
        .err        (err_i),
        .status_clr (status_clr),
        .count_clr  (count_clr),
        .status     (status),
        .count      (count),
        .irq        (irq_o)
    );

endmodule
